// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state encoding and default parameters for the PE sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT, PRST, ACC, STALL, FIN, DRAIN, DONE
  } state_t;

  localparam int DEF_NUM_PE        = 16;
  localparam int DEF_ACC_CYCLES    = 34;
  localparam int DEF_START_DELAY   = 2;
  localparam int DEF_PIX_W         = 16;
  localparam int DEF_DRAIN_TIMEOUT = 64;
  localparam int CNT_W             = 16;

endpackage

// File: rtl/conv_seq_valid_tracker.sv
// rtl/conv_seq_valid_tracker.sv - masked-valid pixel completion counter and drain timer.
module conv_seq_valid_tracker
  import conv_seq_pkg::*;
#(
  parameter int NUM_PE        = DEF_NUM_PE,
  parameter int PIX_W         = DEF_PIX_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              count_en,
  input  logic              drain_tick,
  input  logic [PIX_W-1:0]  num_pixels,
  input  logic [NUM_PE-1:0] lane_mask,
  input  logic [NUM_PE-1:0] valid,
  output logic [PIX_W-1:0]  ofm_count,
  output logic              all_seen,
  output logic              timeout_hit
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  logic [TMR_W-1:0] tmr;
  logic             lane_done;

  // An empty mask never completes a pixel, so such runs can only leave DRAIN by timeout.
  assign lane_done   = count_en && (lane_mask != '0) && ((valid & lane_mask) == lane_mask);
  assign all_seen    = (ofm_count == num_pixels);
  assign timeout_hit = (tmr >= TMR_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      ofm_count <= '0;
    end else if (lane_done && (ofm_count < num_pixels)) begin
      ofm_count <= ofm_count + 1'b1;
    end
  end

  // Counts from the last FIN cycle so the limit is measured from the final pe_finish.
  always_ff @(posedge clk) begin
    if (!reset || !drain_tick) begin
      tmr <= '0;
    end else if (tmr != '1) begin
      tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - pe_reset/pe_finish pulse-train generator with OFM completion tracking.
// Optional CONV_SEQ_STALL_EN: hold before FIN while ofm_ready is low.
module conv_pe_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_PE        = DEF_NUM_PE,
  parameter int ACC_CYCLES    = DEF_ACC_CYCLES,
  parameter int START_DELAY   = DEF_START_DELAY,
  parameter int PIX_W         = DEF_PIX_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  num_pixels,
  input  logic [NUM_PE-1:0] lane_mask,
  input  logic [NUM_PE-1:0] valid,
  input  logic              ofm_ready,
  output logic [NUM_PE-1:0] pe_reset,
  output logic [NUM_PE-1:0] pe_finish,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [PIX_W-1:0]  pixel_idx,
  output logic [PIX_W-1:0]  ofm_count
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cal_prev, start_pend, start_evt, abort_evt;
  logic [PIX_W-1:0]  num_q;
  logic [NUM_PE-1:0] mask_q;
  logic              all_seen, timeout_hit, timeout_set;

  assign start_evt = cal_start && !cal_prev && (state == IDLE);
  assign abort_evt = abort && (state != IDLE);

`ifndef CONV_SEQ_STALL_EN
  logic unused_ofm_ready;
  assign unused_ofm_ready = ofm_ready;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    timeout_set = 1'b0;
    case (state)
      // start_pend gives one cycle to latch the run config before leaving IDLE
      IDLE: if (start_pend) begin
        if (num_q == '0)           state_d = DONE;
        else if (START_DELAY == 0) state_d = PRST;
        else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: if (cnt == CNT_W'(START_DELAY - 1)) state_d = PRST;
            else cnt_d = cnt + 1'b1;
      PRST: begin
        state_d = ACC;
        cnt_d   = '0;
      end
      ACC: if (cnt == CNT_W'(ACC_CYCLES - 1)) begin
`ifdef CONV_SEQ_STALL_EN
        state_d = ofm_ready ? FIN : STALL;
`else
        state_d = FIN;
`endif
      end else begin
        cnt_d = cnt + 1'b1;
      end
`ifdef CONV_SEQ_STALL_EN
      STALL: if (ofm_ready) state_d = FIN;
`endif
      FIN:   state_d = (pixel_idx == num_q) ? DRAIN : PRST;
      DRAIN: if (all_seen) state_d = DONE;
             else if (timeout_hit) begin
               state_d     = DONE;
               timeout_set = 1'b1;
             end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_evt) begin
      state_d     = IDLE;
      timeout_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cal_prev    <= 1'b0;
      start_pend  <= 1'b0;
      num_q       <= '0;
      mask_q      <= '0;
      pe_reset    <= '0;
      pe_finish   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      pixel_idx   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cal_prev   <= cal_start;
      start_pend <= start_evt;
      if (start_evt) begin
        num_q  <= num_pixels;
        mask_q <= lane_mask;
      end
      pe_reset  <= (state_d == PRST) ? mask_q : '0;
      pe_finish <= (state_d == FIN)  ? mask_q : '0;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      if (start_evt)        timeout_err <= 1'b0;
      else if (timeout_set) timeout_err <= 1'b1;
      if (start_evt || abort_evt) pixel_idx <= '0;
      else if (state_d == FIN)    pixel_idx <= pixel_idx + 1'b1;
    end
  end

  conv_seq_valid_tracker #(
    .NUM_PE        (NUM_PE),
    .PIX_W         (PIX_W),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_evt || abort_evt),
    .count_en    (busy),
    .drain_tick  ((state == FIN) || (state == DRAIN)),
    .num_pixels  (num_q),
    .lane_mask   (mask_q),
    .valid       (valid),
    .ofm_count   (ofm_count),
    .all_seen    (all_seen),
    .timeout_hit (timeout_hit)
  );

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - scoreboard bench for conv_pe_sequencer with default parameters.
module tb_conv_pe_sequencer;

  typedef struct { int cyc; logic [15:0] val; } ev_t;
  typedef struct { int cyc; logic terr; logic [15:0] ofm; } dn_t;

  logic        clk = 1'b0;
  logic        reset, cal_start, abort, ofm_ready;
  logic [15:0] num_pixels, lane_mask;
  logic [15:0] valid = '0;
  logic [15:0] pe_reset, pe_finish, pixel_idx, ofm_count;
  logic        busy, done, timeout_err;

  int checks = 0, failures = 0, cyc = 0, n = 0;
  ev_t exp_rst[$], exp_fin[$];
  dn_t exp_done[$];
  logic [15:0] resp_q[$];
  logic        resp_en = 1'b1, fin_d = 1'b0;
  ev_t er, ef;
  dn_t ed;

  conv_pe_sequencer dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .abort(abort),
    .num_pixels(num_pixels), .lane_mask(lane_mask), .valid(valid), .ofm_ready(ofm_ready),
    .pe_reset(pe_reset), .pe_finish(pe_finish), .busy(busy), .done(done),
    .timeout_err(timeout_err), .pixel_idx(pixel_idx), .ofm_count(ofm_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s unexpected actual=%0h required=none (cycle %0d)", name, act, cyc);
  endtask

  // Expected pulse train for a run whose start edge is n0: period 36, first pe_reset at n0+3.
  task automatic expect_run(input int n0, input int np, input logic [15:0] m);
    for (int i = 0; i < np; i++) begin
      exp_rst.push_back('{n0 + 3 + 36 * i, m});
      exp_fin.push_back('{n0 + 38 + 36 * i, m});
    end
  endtask

  task automatic launch(input int np, input logic [15:0] m, output int n0);
    @(negedge clk);
    num_pixels = 16'(np);
    lane_mask  = m;
    cal_start  = 1'b1;
    n0         = cyc + 1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (pe_reset != '0) begin
        if (exp_rst.size() == 0) unexpected("pe_reset", pe_reset);
        else begin
          er = exp_rst.pop_front();
          chk("pe_reset_cycle", cyc, er.cyc);
          chk("pe_reset_value", pe_reset, er.val);
        end
      end
      if (pe_finish != '0) begin
        if (exp_fin.size() == 0) unexpected("pe_finish", pe_finish);
        else begin
          ef = exp_fin.pop_front();
          chk("pe_finish_cycle", cyc, ef.cyc);
          chk("pe_finish_value", pe_finish, ef.val);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done", done);
        else begin
          ed = exp_done.pop_front();
          chk("done_cycle", cyc, ed.cyc);
          chk("done_timeout_err", timeout_err, ed.terr);
          chk("done_ofm_count", ofm_count, ed.ofm);
        end
      end
    end
  end

  // Array model: lanes report valid one cycle after each pe_finish.
  always @(negedge clk) begin
    if (fin_d && resp_en) valid = (resp_q.size() != 0) ? resp_q.pop_front() : 16'hFFFF;
    else                  valid = '0;
    fin_d = (pe_finish != '0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cal_start = 1'b0; abort = 1'b0; ofm_ready = 1'b1;
    num_pixels = '0; lane_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_pe_reset", pe_reset, 0);
    chk("rst_pe_finish", pe_finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pixel_idx", pixel_idx, 0);
    chk("rst_ofm_count", ofm_count, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Four full pixels; cal_start stays high past the end to prove one run per edge.
    launch(4, 16'hFFFF, n);
    expect_run(n, 4, 16'hFFFF);
    exp_done.push_back('{n + 149, 1'b0, 16'd4});
    goto(n);       chk("busy_pending", busy, 0);
    goto(n + 1);   chk("busy_start", busy, 1);
    goto(n + 149); chk("busy_in_done", busy, 1);
    goto(n + 150); chk("busy_after_done", busy, 0);
    chk("pixel_idx_end", pixel_idx, 4);
    chk("ofm_count_end", ofm_count, 4);
    goto(n + 160); cal_start = 1'b0;

    // Zero pixels: done one cycle after start, no PE pulses.
    launch(0, 16'hFFFF, n);
    exp_done.push_back('{n + 1, 1'b0, 16'd0});
    goto(n + 1); chk("busy_zero_run", busy, 1); cal_start = 1'b0;
    goto(n + 2); chk("busy_zero_after", busy, 0);

    // No valid at all: drain timeout 64 cycles after the last pe_finish.
    resp_en = 1'b0;
    launch(3, 16'hFFFF, n);
    expect_run(n, 3, 16'hFFFF);
    exp_done.push_back('{n + 110 + 64, 1'b1, 16'd0});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 176); chk("timeout_sticky", timeout_err, 1);
    resp_en = 1'b1;
    launch(0, 16'hFFFF, n);
    exp_done.push_back('{n + 1, 1'b0, 16'd0});
    goto(n); chk("timeout_cleared", timeout_err, 0);
    goto(n + 1); cal_start = 1'b0;
    goto(n + 3);

    // Abort sampled on the edge that would enter the second FIN.
    launch(3, 16'hFFFF, n);
    exp_rst.push_back('{n + 3, 16'hFFFF});
    exp_rst.push_back('{n + 39, 16'hFFFF});
    exp_fin.push_back('{n + 38, 16'hFFFF});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 73); abort = 1'b1;
    goto(n + 74); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pe_finish", pe_finish, 0);
    goto(n + 150);
    launch(1, 16'hFFFF, n);
    expect_run(n, 1, 16'hFFFF);
    exp_done.push_back('{n + 41, 1'b0, 16'd1});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 45);

    // Partial mask: 00FF counts, 000F does not, so the run times out with one pixel seen.
    resp_q.push_back(16'h00FF);
    resp_q.push_back(16'h000F);
    launch(2, 16'h00FF, n);
    expect_run(n, 2, 16'h00FF);
    exp_done.push_back('{n + 74 + 64, 1'b1, 16'd1});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 140);

    // Reset in the middle of a run.
    launch(2, 16'hFFFF, n);
    exp_rst.push_back('{n + 3, 16'hFFFF});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 19); reset = 1'b0;
    goto(n + 20);
    chk("midrst_busy", busy, 0);
    chk("midrst_pixel_idx", pixel_idx, 0);
    reset = 1'b1;
    goto(n + 80); chk("midrst_stays_idle", busy, 0);

`ifdef CONV_SEQ_STALL_EN
    // ofm_ready low for five decision edges delays pe_finish by five cycles.
    launch(1, 16'hFFFF, n);
    exp_rst.push_back('{n + 3, 16'hFFFF});
    exp_fin.push_back('{n + 43, 16'hFFFF});
    exp_done.push_back('{n + 46, 1'b0, 16'd1});
    goto(n + 1); cal_start = 1'b0;
    goto(n + 37); ofm_ready = 1'b0;
    goto(n + 42); ofm_ready = 1'b1;
    goto(n + 50);
`endif

    chk("left_pe_reset", exp_rst.size(), 0);
    chk("left_pe_finish", exp_fin.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_pe_sequencer.md
# conv_pe_sequencer

Parametrised control sequencer for the convolution PE array: on a `cal_start` rising edge it generates per-pixel `pe_reset`/`pe_finish` pulse trains for a runtime-programmed number of OFM pixels, replacing hand-timed stimulus. It also counts completed OFM pixels from the array's `valid` lanes and signals completion or a drain timeout. It sits between the top-level controller and `Sub_top_CONV`.

## Interface
- `NUM_PE`, 16, PE lanes.
- `ACC_CYCLES`, 34, accumulate cycles between `pe_reset` and `pe_finish` (`NUM_TILES*KERNEL_W*...-2`); ≥1.
- `START_DELAY`, 2, idle cycles after start before first `pe_reset`; ≥0.
- `PIX_W`, 16, pixel counter width.
- `DRAIN_TIMEOUT`, 64, max cycles waiting for outstanding `valid` after last `pe_finish`; ≥1.

- `clk` in 1, clock.
- `reset` in 1, synchronous, active-low.
- `cal_start` in 1, level; rising edge starts a run.
- `abort` in 1, synchronous run cancel.
- `num_pixels` in PIX_W, pixels per run; sampled at start.
- `lane_mask` in NUM_PE, active PE lanes; sampled at start.
- `valid` in NUM_PE, per-lane OFM valid from the array.
- `ofm_ready` in 1, downstream can accept a pixel (used only with stall feature).
- `pe_reset` out NUM_PE, one-cycle accumulator clear per pixel.
- `pe_finish` out NUM_PE, one-cycle accumulate-end per pixel.
- `busy` out 1, run in progress.
- `done` out 1, one-cycle completion pulse.
- `timeout_err` out 1, sticky drain timeout; cleared at next start.
- `pixel_idx` out PIX_W, pixels issued (`pe_finish` count).
- `ofm_count` out PIX_W, pixels observed complete.

## Operation
- Start: `cal_start` high and registered previous value low, state IDLE → latch `num_pixels`, `lane_mask`; clear counters, `timeout_err`. Edges while busy ignored; held-high `cal_start` starts one run only.
- States: IDLE → WAIT (START_DELAY cycles; skipped if 0) → PRST (1 cycle, `pe_reset=mask`) → ACC (ACC_CYCLES cycles) → FIN (1 cycle, `pe_finish=mask`, `pixel_idx++`) → PRST, or DRAIN after last pixel → DONE (1 cycle, `done=1`) → IDLE.
- `num_pixels==0`: start → DONE directly, no PE pulses.
- Pixel completion: a cycle with `busy` and `(valid & mask)==mask`, mask≠0, increments `ofm_count`; saturates at `num_pixels`. Mask 0: nothing counted; DRAIN exits by timeout.
- DRAIN: exit to DONE when `ofm_count==num_pixels`; after DRAIN_TIMEOUT cycles set `timeout_err`, then DONE.
- `abort`: any non-IDLE state → IDLE next edge; outputs cleared; no `done`. Abort wins over simultaneous FIN (no `pe_finish` that cycle).
- Counters: PIX_W-bit unsigned, no wrap.

## Timing
- All outputs registered. Reset values: `pe_reset=0`, `pe_finish=0`, `busy=0`, `done=0`, `timeout_err=0`, `pixel_idx=0`, `ofm_count=0`, state IDLE.
- `cal_start` sampled high at edge N → first `pe_reset` high in cycle after edge N+START_DELAY+1; `busy` high from edge N+1 until DONE exits.
- Per-pixel period ACC_CYCLES+2 cycles (default 36); `pe_finish` exactly ACC_CYCLES+1 cycles after `pe_reset`.
- `done` and `busy` deassert together on the edge leaving DONE; new start accepted the following cycle.
- Reset mid-run: full return to reset values on that edge.

## Configuration
- `CONV_SEQ_STALL_EN` defined: at end of ACC, if `ofm_ready==0`, enter STALL; hold (no pulses, counters frozen) until `ofm_ready==1`, then FIN next cycle. Abort leaves STALL.
- Undefined: `ofm_ready` ignored, STALL state absent, fixed period ACC_CYCLES+2.

## Structure
- Package `conv_seq_pkg`: state enum (IDLE, WAIT, PRST, ACC, STALL, FIN, DRAIN, DONE), default parameter constants.
- Sub-module `conv_seq_valid_tracker`: masked-valid completion detect, `ofm_count` saturating counter, drain timeout counter.

## Test plan
- Defaults, `num_pixels=4`, mask `16'hFFFF`, `valid` all-ones one cycle after each `pe_finish` → 4 `pe_reset`/`pe_finish` pairs 36 cycles apart, first `pe_reset` 3 cycles after edge, `ofm_count=4`, one `done`, `timeout_err=0`.
- `num_pixels=0` → `done` one cycle after start, no PE pulses.
- `num_pixels=3`, `valid` never asserted → `done` DRAIN_TIMEOUT cycles after last `pe_finish`, `timeout_err=1`, `ofm_count=0`; next start clears it.
- `abort` in cycle of second FIN → no second `pe_finish`, `busy=0` next cycle, no `done`; new start then runs normally.
- Mask `16'h00FF`, valid `16'h00FF` → counted; valid `16'h000F` → not counted; `pe_reset=16'h00FF`.
- With `CONV_SEQ_STALL_EN`, `ofm_ready=0` for 5 cycles at end of ACC → `pe_finish` delayed by exactly 5 cycles.
